// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-clock-domain pointer and flag controller for an
// asynchronous FIFO. It drives the memory write port (W_EN, W_ADDR),
// publishes a registered Gray write pointer for the read-domain
// synchronizer, and derives FULL, ALMOST_FULL, the fill level and a sticky
// OVERFLOW flag from the already-synchronized Gray read pointer.
//
// Producer handshake: W_INC is a request and ~FULL acts as the ready.
// A write commits on a rising CLK edge only when W_INC is high and FULL is
// low in that cycle (W_EN shows this in the same cycle). A request made
// while FULL is high is dropped, never queued, and it sets OVERFLOW.
//
// The flags are pessimistic. The synchronized read pointer lags the real
// read pointer, so FULL and W_LEVEL may overstate occupancy for a few
// cycles after a read, but they never understate it.
module fifo_wr_ctrl #(
    parameter int DEPTH    = 8,
    parameter int P_SIZE   = 4,
    parameter int AF_LEVEL = 6
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              W_INC,
    input  logic [P_SIZE-1:0] RQ2_RPTR,
    input  logic              CLR_OVF,
    output logic              W_EN,
    output logic [P_SIZE-2:0] W_ADDR,
    output logic [P_SIZE-1:0] WPTR_GRAY,
    output logic              FULL,
    output logic              ALMOST_FULL,
    output logic [P_SIZE-1:0] W_LEVEL,
    output logic              OVERFLOW
);

    // Address bits; the pointer carries one extra wrap bit on top of these.
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [P_SIZE-1:0] AF_THRESH = P_SIZE'(AF_LEVEL);

    logic [P_SIZE-1:0] wbin;
    logic [P_SIZE-1:0] wbin_next;
    logic [P_SIZE-1:0] wgray_next;
    logic [P_SIZE-1:0] rbin;
    logic [P_SIZE-1:0] level_next;
    logic [P_SIZE-1:0] rptr_full_pattern;
    logic              accept;
    logic              full_next;

    // A write is taken only when the FIFO is not currently full.
    assign accept = W_INC & ~FULL;
    assign W_EN   = accept;
    assign W_ADDR = wbin[ADDR_W-1:0];

    // Next pointer, modulo 2^P_SIZE, and its Gray image for the register.
    assign wbin_next  = wbin + {{(P_SIZE-1){1'b0}}, accept};
    assign wgray_next = wbin_next ^ (wbin_next >> 1);

    // Gray-to-binary of the synchronized read pointer: each bit is the XOR
    // of itself and every more-significant Gray bit.
    always_comb begin
        rbin = '0;
        for (int i = 0; i < P_SIZE; i++) begin
            rbin[i] = ^(RQ2_RPTR >> i);
        end
    end

    // Occupancy after this edge; modular subtraction survives the wrap.
    assign level_next = wbin_next - rbin;

    // In Gray code, "write pointer is exactly DEPTH ahead" means the top two
    // bits are inverted and all lower bits match.
    assign rptr_full_pattern = {~RQ2_RPTR[P_SIZE-1:P_SIZE-2], RQ2_RPTR[P_SIZE-3:0]};
    assign full_next         = (wgray_next == rptr_full_pattern);

    // Advance the binary pointer and its registered Gray copy together.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wbin      <= '0;
            WPTR_GRAY <= '0;
        end else begin
            wbin      <= wbin_next;
            WPTR_GRAY <= wgray_next;
        end
    end

    // Register the occupancy-derived flags on the edge that commits a write.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            FULL        <= 1'b0;
            ALMOST_FULL <= 1'b0;
            W_LEVEL     <= '0;
        end else begin
            FULL        <= full_next;
            ALMOST_FULL <= (level_next >= AF_THRESH);
            W_LEVEL     <= level_next;
        end
    end

    // Sticky overflow: a dropped write sets it, and a set in the same cycle
    // as a clear takes priority so no overflow event is ever lost.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OVERFLOW <= 1'b0;
        end else if (W_INC & FULL) begin
            OVERFLOW <= 1'b1;
        end else if (CLR_OVF) begin
            OVERFLOW <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: directed bench for fifo_wr_ctrl (DEPTH=8, P_SIZE=4,
// AF_LEVEL=6). Inputs are driven on the falling edge; registered outputs are
// sampled 1 ns after the rising edge, combinational outputs 1 ns after the
// inputs change.
module tb_fifo_wr_ctrl;

  logic       CLK;
  logic       RST;
  logic       W_INC;
  logic [3:0] RQ2_RPTR;
  logic       CLR_OVF;
  logic       W_EN;
  logic [2:0] W_ADDR;
  logic [3:0] WPTR_GRAY;
  logic       FULL;
  logic       ALMOST_FULL;
  logic [3:0] W_LEVEL;
  logic       OVERFLOW;

  int vectors = 0;
  int errors  = 0;

  fifo_wr_ctrl #(
    .DEPTH    (8),
    .P_SIZE   (4),
    .AF_LEVEL (6)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .W_INC       (W_INC),
    .RQ2_RPTR    (RQ2_RPTR),
    .CLR_OVF     (CLR_OVF),
    .W_EN        (W_EN),
    .W_ADDR      (W_ADDR),
    .WPTR_GRAY   (WPTR_GRAY),
    .FULL        (FULL),
    .ALMOST_FULL (ALMOST_FULL),
    .W_LEVEL     (W_LEVEL),
    .OVERFLOW    (OVERFLOW)
  );

  // Clock: 10 ns period, rising edges at 5, 15, 25, ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [3:0] gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic after_rise();
    @(posedge CLK);
    #1;
  endtask

  logic [3:0] gray_tab [8];
  logic [3:0] w_model;
  logic [3:0] prev_gray;

  initial begin
    gray_tab = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};
    W_INC    = 1'b0;
    RQ2_RPTR = 4'h0;
    CLR_OVF  = 1'b0;
    RST      = 1'b0;
    #1 RST   = 1'b1;
    #1;
    // Reset state, checked asynchronously before any clock edge.
    chk4("rst_gray",  WPTR_GRAY, 4'h0);
    chk4("rst_level", W_LEVEL,   4'h0);
    chk1("rst_full",  FULL,      1'b0);
    chk1("rst_af",    ALMOST_FULL, 1'b0);
    chk1("rst_ovf",   OVERFLOW,  1'b0);
    chk4("rst_addr",  {1'b0, W_ADDR}, 4'h0);
    @(negedge CLK);
    RST = 1'b0;

    // Fill: eight back-to-back writes with the read pointer at 0.
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      W_INC = 1'b1;
      #1;
      chk1("fill_wen", W_EN, 1'b1);
      chk4("fill_addr", {1'b0, W_ADDR}, 4'(i));
      after_rise();
      chk4("fill_gray",  WPTR_GRAY, gray_tab[i]);
      chk4("fill_level", W_LEVEL, 4'(i + 1));
      chk1("fill_af",    ALMOST_FULL, (i + 1) >= 6);
      chk1("fill_full",  FULL, i == 7);
    end

    // Overflow: two blocked writes while full.
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      W_INC = 1'b1;
      #1;
      chk1("ovf_wen_blocked", W_EN, 1'b0);
      after_rise();
      chk4("ovf_gray_hold", WPTR_GRAY, 4'hC);
      chk1("ovf_set",       OVERFLOW, 1'b1);
      chk1("ovf_full_hold", FULL, 1'b1);
      chk4("ovf_level",     W_LEVEL, 4'h8);
    end
    @(negedge CLK);
    W_INC   = 1'b0;
    CLR_OVF = 1'b1;
    after_rise();
    chk1("ovf_clear", OVERFLOW, 1'b0);
    @(negedge CLK);
    W_INC   = 1'b1;
    CLR_OVF = 1'b1;
    after_rise();
    chk1("ovf_set_wins", OVERFLOW, 1'b1);
    chk4("ovf_set_wins_gray", WPTR_GRAY, 4'hC);

    // Drain release: read pointer advances to 1 (Gray 0001).
    @(negedge CLK);
    W_INC    = 1'b0;
    CLR_OVF  = 1'b0;
    RQ2_RPTR = 4'h1;
    after_rise();
    chk1("drain_full",  FULL, 1'b0);
    chk4("drain_level", W_LEVEL, 4'h7);
    chk1("drain_af",    ALMOST_FULL, 1'b1);
    @(negedge CLK);
    W_INC = 1'b1;
    #1;
    chk1("refill_wen",  W_EN, 1'b1);
    chk4("refill_addr", {1'b0, W_ADDR}, 4'h0);
    after_rise();
    chk1("refill_full",  FULL, 1'b1);
    chk4("refill_level", W_LEVEL, 4'h8);
    chk4("refill_gray",  WPTR_GRAY, 4'hD);

    // Wrap: write pointer is now 9. Pull the read pointer to 7 (level 2),
    // then stream 40 writes with the read pointer trailing.
    w_model = 4'd9;
    @(negedge CLK);
    W_INC    = 1'b0;
    RQ2_RPTR = gray(4'd7);
    after_rise();
    chk4("wrap_pre_level", W_LEVEL, 4'h2);
    chk1("wrap_pre_full",  FULL, 1'b0);
    for (int i = 0; i < 40; i++) begin
      prev_gray = WPTR_GRAY;
      @(negedge CLK);
      W_INC    = 1'b1;
      RQ2_RPTR = gray(w_model - 4'd1);
      #1;
      chk1("wrap_wen",  W_EN, 1'b1);
      chk4("wrap_addr", {1'b0, W_ADDR}, {1'b0, w_model[2:0]});
      after_rise();
      w_model = w_model + 4'd1;
      chk4("wrap_gray_onebit", 4'($countones(WPTR_GRAY ^ prev_gray)), 4'h1);
      chk4("wrap_level", W_LEVEL, 4'h2);
      chk1("wrap_full",  FULL, 1'b0);
      if (w_model == 4'd0) begin
        chk4("wrap_gray_zero", WPTR_GRAY, 4'h0);
      end
    end

    // Simultaneous: write pointer 1, set read pointer 12 -> level 5; then
    // write and advance read together, level must hold at 5.
    @(negedge CLK);
    W_INC    = 1'b0;
    RQ2_RPTR = gray(4'd12);
    after_rise();
    chk4("sim_pre_level", W_LEVEL, 4'h5);
    chk1("sim_pre_af",    ALMOST_FULL, 1'b0);
    @(negedge CLK);
    W_INC    = 1'b1;
    RQ2_RPTR = gray(4'd13);
    after_rise();
    chk4("sim_level", W_LEVEL, 4'h5);
    chk1("sim_af",    ALMOST_FULL, 1'b0);
    chk4("sim_gray",  WPTR_GRAY, 4'h3);

    // Two more writes to reach level 7 (pointer 4, read 13).
    @(negedge CLK);
    W_INC = 1'b1;
    after_rise();
    chk4("lvl6", W_LEVEL, 4'h6);
    chk1("lvl6_af", ALMOST_FULL, 1'b1);
    after_rise();
    chk4("lvl7", W_LEVEL, 4'h7);
    chk4("lvl7_gray", WPTR_GRAY, 4'h6);

    // Reset between edges: outputs clear before the next rising edge.
    @(negedge CLK);
    W_INC = 1'b0;
    #2 RST = 1'b1;
    #1;
    chk4("mid_rst_gray",  WPTR_GRAY, 4'h0);
    chk4("mid_rst_level", W_LEVEL, 4'h0);
    chk1("mid_rst_af",    ALMOST_FULL, 1'b0);
    chk1("mid_rst_full",  FULL, 1'b0);
    chk1("mid_rst_ovf",   OVERFLOW, 1'b0);
    chk4("mid_rst_addr",  {1'b0, W_ADDR}, 4'h0);
    chk1("mid_rst_wen",   W_EN, 1'b0);

    // First edge after reset release accepts a write.
    @(negedge CLK);
    RST      = 1'b0;
    RQ2_RPTR = 4'h0;
    W_INC    = 1'b1;
    #1;
    chk1("post_rst_wen", W_EN, 1'b1);
    after_rise();
    chk4("post_rst_gray",  WPTR_GRAY, 4'h1);
    chk4("post_rst_level", W_LEVEL, 4'h1);
    @(negedge CLK);
    W_INC = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_ctrl.md
# fifo_wr_ctrl

Write-side pointer and flag controller for the asynchronous FIFO. It runs in the write clock domain and sequences the FIFO memory's write port: it generates the write address and write enable, and produces the Gray-coded write pointer that is handed to the read domain's double-flop synchronizer. It computes FULL, ALMOST_FULL, fill level and a sticky overflow flag from the read pointer after that pointer has passed through a write-domain synchronizer.

## Interface
Parameters:
- DEPTH, 8, number of FIFO entries; must be a power of two, at least 4
- P_SIZE, 4, pointer width, equal to log2(DEPTH)+1 (address bits plus one wrap bit)
- AF_LEVEL, 6, fill level at or above which ALMOST_FULL asserts; range 1..DEPTH

Ports:
- CLK  in  1  write-domain clock
- RST  in  1  reset; asynchronous, active-high
- W_INC  in  1  write request from the producer
- RQ2_RPTR  in  P_SIZE  Gray read pointer, already synchronized into CLK
- CLR_OVF  in  1  clears OVERFLOW
- W_EN  out  1  write strobe to the FIFO memory
- W_ADDR  out  P_SIZE-1  write address to the FIFO memory
- WPTR_GRAY  out  P_SIZE  registered Gray write pointer, sent to the read-domain synchronizer
- FULL  out  1  FIFO full, registered
- ALMOST_FULL  out  1  fill level >= AF_LEVEL, registered
- W_LEVEL  out  P_SIZE  write-side fill level, 0..DEPTH, registered
- OVERFLOW  out  1  sticky flag: a write was attempted while FULL

## Operation
- Internal state is a binary write pointer `wbin` of P_SIZE bits. WPTR_GRAY is a register and is never decoded from `wbin` combinationally.
- `accept = W_INC & ~FULL`. W_EN equals `accept` (combinational). W_ADDR equals `wbin[P_SIZE-2:0]` (combinational from the register).
- `wbin_next = wbin + accept`, modulo 2^P_SIZE. `wgray_next = wbin_next ^ (wbin_next >> 1)`.
- On each clock: `wbin <= wbin_next` and `WPTR_GRAY <= wgray_next`. Only one bit of WPTR_GRAY changes per cycle.
- Read pointer conversion: `rbin` is the Gray-to-binary value of RQ2_RPTR. It is computed combinationally, MSB first: `rbin[i] = ^RQ2_RPTR[P_SIZE-1:i]`.
- Full detection: `FULL <= (wgray_next == {~RQ2_RPTR[P_SIZE-1:P_SIZE-2], RQ2_RPTR[P_SIZE-3:0]})`.
- Level: `W_LEVEL <= wbin_next - rbin`, modulo 2^P_SIZE. The value never exceeds DEPTH.
- Almost full: `ALMOST_FULL <= (wbin_next - rbin) >= AF_LEVEL`.
- Overflow: OVERFLOW is set when `W_INC & FULL`. It is cleared by CLR_OVF. If both occur in the same cycle, set wins.
- A write attempted while FULL is dropped: W_EN stays 0 and the pointer holds.
- The flags are pessimistic. The synchronized read pointer lags, so FULL and the level may overstate occupancy for 2–3 cycles after a read. They never understate it.

## Timing
- Reset (RST high, asynchronous): `wbin`=0, WPTR_GRAY=0, FULL=0, ALMOST_FULL=0, W_LEVEL=0, OVERFLOW=0.
- Reset asserted mid-operation clears all state immediately, whatever the pointer value.
- The first edge after RST deasserts may accept a write.
- W_EN is same-cycle with W_INC, gated by the current FULL.
- WPTR_GRAY, FULL, W_LEVEL and ALMOST_FULL update on the same edge that commits the write. FULL goes high on the edge that completes write number DEPTH, so a W_INC in the next cycle is blocked.
- An RQ2_RPTR change deasserts FULL and updates W_LEVEL on the next edge (one-cycle latency).
- Simultaneous accepted write and RQ2_RPTR advance: both are reflected on the same edge, and the level is unchanged.
- Wrap-around: `wbin` rolls from 2^P_SIZE-1 to 0. W_ADDR wraps at DEPTH and the MSB toggles. Level arithmetic stays correct through the wrap because it is computed modulo 2^P_SIZE.

## Test plan
- Reset and fill: RST pulse, RQ2_RPTR=0, then 8 consecutive W_INC.
  - W_ADDR must read 0..7.
  - WPTR_GRAY must step 1,3,2,6,7,5,4,C.
  - FULL must be 1 after the 8th edge.
  - W_LEVEL must be 8.
  - ALMOST_FULL must rise after the 6th write.
- Overflow: while FULL, hold W_INC for 2 cycles.
  - W_EN must stay 0 and WPTR_GRAY must stay C.
  - OVERFLOW must be 1.
  - CLR_OVF pulse must return OVERFLOW to 0.
  - CLR_OVF together with W_INC while FULL must leave OVERFLOW at 1.
- Drain release: from full, set RQ2_RPTR=1 (Gray of 1).
  - FULL must be 0 and W_LEVEL must be 7 one edge later.
  - The next W_INC must write address 0 and make FULL 1 again.
- Wrap: run continuous writes with RQ2_RPTR tracking write progress, trailing by 2 entries, for 40 cycles.
  - `wbin` must wrap 15→0 cleanly.
  - WPTR_GRAY must change exactly one bit per accepted write.
  - W_LEVEL must never exceed 8, and FULL must never assert.
- Simultaneous: at level 5, assert W_INC on the same edge RQ2_RPTR advances by one.
  - W_LEVEL must stay 5.
  - ALMOST_FULL must stay 0.
- Reset mid-operation: at level 7, assert RST between edges.
  - All outputs must read 0 immediately, before the next edge.
